// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALU    = 1'b1;
  localparam logic [1:0] A_PC       = 2'd0;
  localparam logic [1:0] A_OLDPC    = 2'd1;
  localparam logic [1:0] A_RS1      = 2'd2;
  localparam logic [1:0] B_RS2      = 2'd0;
  localparam logic [1:0] B_IMM      = 2'd1;
  localparam logic [1:0] B_FOUR     = 2'd2;
  localparam logic [1:0] RES_ALUREG = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // beq is the only branch taken on a set zero flag; the ALU inverts the rest.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    return (f3 == 3'b000) ? z : !z;
  endfunction

  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b010) || (f3 == 3'b011));
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// rtl/alu_op_dec.sv - maps controller state and instruction fields to the ALU operation
module alu_op_dec
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_ctrl,
  output logic [2:0] alu_funct3,
  output logic [6:0] alu_funct7
);

  always_comb begin
    alu_ctrl   = ALU_ADD;
    alu_funct3 = 3'b000;
    alu_funct7 = 7'b0000000;
    case (state)
      S_EXEC_R, S_EXEC_I: begin
        alu_ctrl   = funct3;
        alu_funct3 = funct3;
        // immediates reuse funct7 bits as imm[11:5]; only shifts may see them
        if ((opcode == OP_R) || (funct3 == ALU_SR)) alu_funct7 = funct7;
      end
      S_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: begin
            alu_ctrl   = ALU_ADD;
            alu_funct3 = 3'b000;
            alu_funct7 = F7_SUB;
          end
          3'b100: begin alu_ctrl = ALU_SLT;  alu_funct3 = 3'b010; end
          3'b101: begin alu_ctrl = ALU_SLT;  alu_funct3 = 3'b101; end
          3'b110: begin alu_ctrl = ALU_SLTU; alu_funct3 = 3'b011; end
          3'b111: begin alu_ctrl = ALU_SLTU; alu_funct3 = 3'b111; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with req/ready memory handshake
// Define CTRL_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter state_t      RESET_STATE = S_FETCH,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_sel,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [1:0]  result_sel,
  output logic [2:0]  alu_ctrl,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        illegal,
  output logic        mem_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        req_int;
  logic [2:0]  dec_ctrl, dec_funct3;
  logic [6:0]  dec_funct7;

  alu_op_dec u_alu_op_dec (
    .state      (state_q),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .alu_ctrl   (dec_ctrl),
    .alu_funct3 (dec_funct3),
    .alu_funct7 (dec_funct7)
  );

  assign req_int = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    tmo_cnt_d = '0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH: begin
            if (branch_f3_legal(funct3)) begin
              state_d = S_BRANCH;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH:         state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR:  state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    // only consecutive stalled request cycles count toward the timeout
    if ((MEM_TIMEOUT != 0) && req_int && !mem_ready) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      if (tmo_cnt_d == MEM_TIMEOUT) begin
        mem_err_d = 1'b1;
        state_d   = S_HALT;
        tmo_cnt_d = '0;
      end
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_sel    = ADR_PC;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    alu_a_sel  = A_PC;
    alu_b_sel  = B_RS2;
    result_sel = RES_ALUREG;
    alu_ctrl   = ALU_ADD;
    alu_funct3 = 3'b000;
    alu_funct7 = 7'b0000000;
    // reset masks every output combinationally so an in-flight request drops at once
    if (!rst) begin
      alu_ctrl   = dec_ctrl;
      alu_funct3 = dec_funct3;
      alu_funct7 = dec_funct7;
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_b_sel  = B_FOUR;
          result_sel = RES_ALU;
          ir_we      = mem_ready;
          pc_we      = mem_ready;
        end
        S_DECODE: begin
          alu_a_sel = A_OLDPC;
          alu_b_sel = (opcode == OP_JALR) ? B_FOUR : B_IMM;
        end
        S_MEMADR: begin
          alu_a_sel = A_RS1;
          alu_b_sel = B_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_sel = ADR_ALU;
        end
        S_MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_sel = ADR_ALU;
        end
        S_MEMWB: begin
          reg_we     = 1'b1;
          result_sel = RES_MEM;
        end
        S_EXEC_R: alu_a_sel = A_RS1;
        S_EXEC_I: begin
          alu_a_sel = A_RS1;
          alu_b_sel = B_IMM;
        end
        S_ALUWB:  reg_we = 1'b1;
        S_BRANCH: begin
          alu_a_sel = A_RS1;
          pc_we     = branch_taken(funct3, zero);
        end
        S_JAL: begin
          alu_a_sel = A_OLDPC;
          alu_b_sel = B_FOUR;
          pc_we     = 1'b1;
        end
        S_JALR: begin
          alu_a_sel  = A_RS1;
          alu_b_sel  = B_IMM;
          result_sel = RES_ALU;
          pc_we      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign mem_err = mem_err_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEMWRITE) || (state_q == S_MEMWB) ||
                   (state_q == S_ALUWB) || (state_q == S_BRANCH));

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    instret_cnt_d = instret_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] OPL  = 7'b0000011;
  localparam logic [6:0] OPS  = 7'b0100011;
  localparam logic [6:0] OPR  = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPB  = 7'b1100011;
  localparam logic [6:0] OPJ  = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;
  localparam logic [6:0] F7S  = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, adr_sel, pc_we, ir_we, reg_we, illegal, mem_err;
  logic [1:0]  alu_a_sel, alu_b_sel, result_sel;
  logic [2:0]  alu_ctrl, alu_funct3;
  logic [6:0]  alu_funct7;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_sel    (adr_sel),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .result_sel (result_sel),
    .alu_ctrl   (alu_ctrl),
    .alu_funct3 (alu_funct3),
    .alu_funct7 (alu_funct7),
    .illegal    (illegal),
    .mem_err    (mem_err)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, adr, pcwe, irwe, regwe;
    logic [1:0] a, b, res;
    logic [2:0] ctrl, f3;
    logic [6:0] f7;
    logic       ill, err;
  } outs_t;

  typedef struct {
    string      name;
    logic       r;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, rdy;
    outs_t      x;
  } vec_t;

  outs_t act;
  assign act = {mem_req, mem_we, adr_sel, pc_we, ir_we, reg_we, alu_a_sel, alu_b_sel,
                result_sel, alu_ctrl, alu_funct3, alu_funct7, illegal, mem_err};

  int    n_checks = 0;
  int    n_fail = 0;
  vec_t  vecs[$];
  outs_t expq[$];
  string nameq[$];

  function automatic outs_t e(input logic req, we, adr, pcwe, irwe, regwe,
                              input logic [1:0] a, b, res,
                              input logic [2:0] c, f3, input logic [6:0] f7,
                              input logic ill, err);
    return {req, we, adr, pcwe, irwe, regwe, a, b, res, c, f3, f7, ill, err};
  endfunction

  task automatic add(input string n, input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic z, input logic rdy, input outs_t x);
    vecs.push_back('{n, r, op, f3, f7, z, rdy, x});
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    outs_t z0, fw, fd, dec, wb;
    z0  = '0;
    fw  = e(1,0,0,0,0,0, 2'd0,2'd2,2'd2, 3'd0,3'd0,7'd0, 0,0);
    fd  = e(1,0,0,1,1,0, 2'd0,2'd2,2'd2, 3'd0,3'd0,7'd0, 0,0);
    dec = e(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd0,3'd0,7'd0, 0,0);
    wb  = e(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 0,0);

    add("reset",        1, OPR, 3'd0, 7'd0, 0, 1, z0);
    add("add fetch",    0, OPR, 3'd0, 7'd0, 0, 1, fd);
    add("add decode",   0, OPR, 3'd0, 7'd0, 0, 0, dec);
    add("add exec",     0, OPR, 3'd0, 7'd0, 0, 0, e(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("add wb",       0, OPR, 3'd0, 7'd0, 0, 0, wb);
    add("addi fetch",   0, OPI, 3'd0, F7S, 0, 1, fd);
    add("addi decode",  0, OPI, 3'd0, F7S, 0, 0, dec);
    add("addi exec",    0, OPI, 3'd0, F7S, 0, 0, e(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("addi wb",      0, OPI, 3'd0, F7S, 0, 0, wb);
    add("srai fetch",   0, OPI, 3'd5, F7S, 0, 1, fd);
    add("srai decode",  0, OPI, 3'd5, F7S, 0, 0, dec);
    add("srai exec",    0, OPI, 3'd5, F7S, 0, 0, e(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd5,3'd5,F7S, 0,0));
    add("srai wb",      0, OPI, 3'd5, F7S, 0, 0, wb);
    add("sub fetch",    0, OPR, 3'd0, F7S, 0, 1, fd);
    add("sub decode",   0, OPR, 3'd0, F7S, 0, 0, dec);
    add("sub exec",     0, OPR, 3'd0, F7S, 0, 0, e(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0,3'd0,F7S, 0,0));
    add("sub wb",       0, OPR, 3'd0, F7S, 0, 0, wb);
    add("bge fetch",    0, OPB, 3'd5, 7'd0, 0, 1, fd);
    add("bge decode",   0, OPB, 3'd5, 7'd0, 0, 0, dec);
    add("bge taken",    0, OPB, 3'd5, 7'd0, 0, 0, e(0,0,0,1,0,0, 2'd2,2'd0,2'd0, 3'd2,3'd5,7'd0, 0,0));
    add("bge2 fetch",   0, OPB, 3'd5, 7'd0, 1, 1, fd);
    add("bge2 decode",  0, OPB, 3'd5, 7'd0, 1, 0, dec);
    add("bge not taken",0, OPB, 3'd5, 7'd0, 1, 0, e(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd2,3'd5,7'd0, 0,0));
    add("beq fetch",    0, OPB, 3'd0, 7'd0, 1, 1, fd);
    add("beq decode",   0, OPB, 3'd0, 7'd0, 1, 0, dec);
    add("beq taken",    0, OPB, 3'd0, 7'd0, 1, 0, e(0,0,0,1,0,0, 2'd2,2'd0,2'd0, 3'd0,3'd0,F7S, 0,0));
    add("bltu fetch",   0, OPB, 3'd6, 7'd0, 0, 1, fd);
    add("bltu decode",  0, OPB, 3'd6, 7'd0, 0, 0, dec);
    add("bltu taken",   0, OPB, 3'd6, 7'd0, 0, 0, e(0,0,0,1,0,0, 2'd2,2'd0,2'd0, 3'd3,3'd3,7'd0, 0,0));
    for (int i = 0; i < 3; i++) add("lw fetch wait", 0, OPL, 3'd2, 7'd0, 0, 0, fw);
    add("lw fetch",     0, OPL, 3'd2, 7'd0, 0, 1, fd);
    add("lw decode",    0, OPL, 3'd2, 7'd0, 0, 1, dec);
    add("lw memadr",    0, OPL, 3'd2, 7'd0, 0, 1, e(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0,3'd0,7'd0, 0,0));
    for (int i = 0; i < 3; i++)
      add("lw memread wait", 0, OPL, 3'd2, 7'd0, 0, 0, e(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("lw memread",   0, OPL, 3'd2, 7'd0, 0, 1, e(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("lw memwb",     0, OPL, 3'd2, 7'd0, 0, 0, e(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 3'd0,3'd0,7'd0, 0,0));
    add("sw fetch",     0, OPS, 3'd2, 7'd0, 0, 1, fd);
    add("sw decode",    0, OPS, 3'd2, 7'd0, 0, 0, dec);
    add("sw memadr",    0, OPS, 3'd2, 7'd0, 0, 0, e(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("sw write wait",0, OPS, 3'd2, 7'd0, 0, 0, e(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("sw write",     0, OPS, 3'd2, 7'd0, 0, 1, e(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("jal fetch",    0, OPJ, 3'd0, 7'd0, 0, 1, fd);
    add("jal decode",   0, OPJ, 3'd0, 7'd0, 0, 0, dec);
    add("jal exec",     0, OPJ, 3'd0, 7'd0, 0, 0, e(0,0,0,1,0,0, 2'd1,2'd2,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("jal wb",       0, OPJ, 3'd0, 7'd0, 0, 0, wb);
    add("jalr fetch",   0, OPJR, 3'd0, 7'd0, 0, 1, fd);
    add("jalr decode",  0, OPJR, 3'd0, 7'd0, 0, 0, e(0,0,0,0,0,0, 2'd1,2'd2,2'd0, 3'd0,3'd0,7'd0, 0,0));
    add("jalr exec",    0, OPJR, 3'd0, 7'd0, 0, 0, e(0,0,0,1,0,0, 2'd2,2'd1,2'd2, 3'd0,3'd0,7'd0, 0,0));
    add("jalr wb",      0, OPJR, 3'd0, 7'd0, 0, 0, wb);
    add("bad fetch",    0, 7'd0, 3'd0, 7'd0, 0, 1, fd);
    add("bad decode",   0, 7'd0, 3'd0, 7'd0, 0, 0, dec);
    add("halt 1",       0, 7'd0, 3'd0, 7'd0, 0, 1, e(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 1,0));
    add("halt 2",       0, OPR, 3'd0, 7'd0, 0, 1, e(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0,7'd0, 1,0));
    add("reset clears", 1, OPR, 3'd0, 7'd0, 0, 1, z0);
    add("refetch",      0, OPR, 3'd0, 7'd0, 0, 1, fd);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].r;
      opcode = vecs[i].op;
      funct3 = vecs[i].f3;
      funct7 = vecs[i].f7;
      zero = vecs[i].z;
      mem_ready = vecs[i].rdy;
      expq.push_back(vecs[i].x);
      nameq.push_back(vecs[i].name);
      @(negedge clk);
      begin
        outs_t want;
        string n;
        want = expq.pop_front();
        n = nameq.pop_front();
        n_checks++;
        if (act !== want) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", n, act, want);
        end
      end
      @(posedge clk);
      #1;
    end

    // memory timeout: request held with no ready for four cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo req held", {31'd0, mem_req}, 32'd1);
      chk("tmo err early", {31'd0, mem_err}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("tmo err set", {31'd0, mem_err}, 32'd1);
    chk("tmo halted req", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("tmo err sticky", {31'd0, mem_err}, 32'd1);
    chk("tmo no ir_we", {31'd0, ir_we}, 32'd0);

    // branch with an undefined funct3 is illegal
    do_reset();
    opcode = OPB;
    funct3 = 3'd2;
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bad branch illegal", {31'd0, illegal}, 32'd1);
    chk("bad branch no pc_we", {31'd0, pc_we}, 32'd0);
    chk("bad branch no req", {31'd0, mem_req}, 32'd0);

    // reset asserted mid-MEMREAD drops the request immediately
    do_reset();
    opcode = OPL;
    funct3 = 3'd2;
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("memread req", {31'd0, mem_req}, 32'd1);
    chk("memread adr", {31'd0, adr_sel}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst drops req", {31'd0, mem_req}, 32'd0);
    chk("rst drops adr", {31'd0, adr_sel}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("restart fetch req", {31'd0, mem_req}, 32'd1);
    chk("restart fetch adr", {31'd0, adr_sel}, 32'd0);
    chk("restart ir_we", {31'd0, ir_we}, 32'd1);
    chk("restart no reg_we", {31'd0, reg_we}, 32'd0);

`ifdef CTRL_PERF_CNT_EN
    do_reset();
    opcode = OPR;
    funct3 = 3'd0;
    funct7 = 7'd0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("instret reset", instret_cnt, 32'd0);
    chk("cycle reset", cycle_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 mem_ready = 1'b0;
    end
    @(negedge clk);
    chk("instret before wb", instret_cnt, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("instret after add", instret_cnt, 32'd1);
    chk("cycle after add", cycle_cnt, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. Sequences the shared 32-bit ALU through fetch, decode, execute, memory and writeback.
- Generates the ALUControl code and the funct3/funct7 values the ALU sees, so branch and immediate cases select the correct ALU sub-operation.
- Drives datapath mux selects, write enables and a req/ready memory handshake.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.
- MEM_TIMEOUT, 0, cycles waiting on mem_ready before memory error is raised; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  store when high
- adr_sel  out  1  0=PC, 1=ALU result register
- pc_we  out  1  PC write enable
- ir_we  out  1  IR/oldPC capture
- reg_we  out  1  register file write
- alu_a_sel  out  2  0=PC, 1=oldPC, 2=rs1
- alu_b_sel  out  2  0=rs2, 1=imm, 2=const 4
- result_sel  out  2  0=ALU reg, 1=mem data, 2=ALU result
- alu_ctrl  out  3  ALU operation code
- alu_funct3  out  3  funct3 presented to ALU
- alu_funct7  out  7  funct7 presented to ALU
- illegal  out  1  sticky: unsupported opcode decoded
- mem_err  out  1  sticky: handshake timeout

Behaviour:
- Reset:
  - State goes to S_FETCH immediately and asynchronously.
  - All enables and requests are 0; all selects, alu_ctrl and alu_funct* are 0.
  - illegal and mem_err are cleared.
  - A reset mid-access drops mem_req at once. No write enable may pulse on the cycle reset deasserts.
- States and transitions:
  - S_FETCH: mem_req=1, adr_sel=0. Hold until mem_ready. On mem_ready: ir_we=1; PC<=PC+4 (a_sel=0, b_sel=2, alu_ctrl=000, result_sel=2, pc_we=1). Go to S_DECODE.
  - S_DECODE: compute oldPC+imm (branch target) into the ALU reg.
    - opcode 0000011/0100011 -> S_MEMADR; 0110011 -> S_EXEC_R; 0010011 -> S_EXEC_I; 1100011 -> S_BRANCH; 1101111 -> S_JAL; 1100111 -> S_JALR.
    - Any other opcode -> set illegal, go to S_HALT.
  - S_MEMADR: rs1+imm, alu_ctrl=000, alu_funct7=0. Load -> S_MEMREAD; store -> S_MEMWRITE.
  - S_MEMREAD: mem_req=1, adr_sel=1; wait mem_ready, then S_MEMWB.
  - S_MEMWRITE: mem_req=1, mem_we=1, adr_sel=1; on mem_ready -> S_FETCH.
  - S_MEMWB: reg_we=1, result_sel=1 -> S_FETCH.
  - S_EXEC_R / S_EXEC_I -> S_ALUWB. S_ALUWB: reg_we=1, result_sel=0 -> S_FETCH.
  - S_BRANCH: one cycle; pc_we from the branch rule below, result_sel=0 (target) -> S_FETCH.
  - S_JAL: PC<=ALU reg target; ALU computes oldPC+4 -> S_ALUWB.
  - S_JALR: rs1+imm -> PC (result_sel=2); the ALU reg keeps oldPC+4 from S_DECODE. Needs two cycles: S_JALR computes rs1+imm, then S_ALUWB.
  - S_HALT: absorbing until reset.
- ALU op mapping (alu_ctrl = funct3, except as noted):
  - funct3 000: sub only for R-type with funct7=0100000. I-type forces alu_funct7=0.
  - funct3 101: alu_funct7 passes through, selecting srai/srli.
- Branch mapping:
  - beq/bne: alu_ctrl=000, alu_funct3=000, alu_funct7=0100000. Taken = zero (beq) / !zero (bne).
  - blt: 010/funct3=010; bge: 010/funct3=101. Taken = !zero in both cases.
  - bltu: 011/011; bgeu: 011/111. Taken = !zero.
  - funct3 010/011 under branch -> illegal.
- Memory handshake: mem_req, mem_we and adr_sel stay stable until the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Timeout (MEM_TIMEOUT>0): counter counts cycles of mem_req=1 && !mem_ready. Reaching MEM_TIMEOUT sets mem_err and goes to S_HALT.

Optional Feature:
- CTRL_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[31:0] (increments every cycle after reset) and instret_cnt[31:0] (increments on each transition into S_FETCH from a completing state).
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and the counters do not exist.

Decomposition:
- Package ctrl_pkg:
  - state_t enum.
  - Opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR).
  - ALU code constants ALU_ADD..ALU_AND matching the 3-bit encoding.
  - Mux select constants.
- Sub-module alu_op_dec: combinational, state+opcode+funct3+funct7 -> alu_ctrl, alu_funct3, alu_funct7.

Test Plan:
- add x3,x1,x2 (R, funct7=0): FETCH(mem_ready 1st cycle)->DECODE->EXEC_R->ALUWB. reg_we=1 exactly in cycle 4; alu_ctrl=000, alu_funct7=0.
- addi with imm[11:5]=0100000: alu_funct7 forced 0 in S_EXEC_I. srai with the same bits passes 0100000 with alu_ctrl=101.
- bge, zero=0: alu_ctrl=010, alu_funct3=101, pc_we=1 in S_BRANCH. Same with zero=1 -> pc_we=0.
- lw with mem_ready delayed 3 cycles in FETCH and MEMREAD: mem_req held high and stable throughout. reg_we asserted once, result_sel=1.
- opcode 0000000 -> illegal=1, S_HALT, no enables. Assert rst mid-MEMREAD -> mem_req=0 same cycle, restart at S_FETCH.
- MEM_TIMEOUT=4, mem_ready never: mem_err=1 after 4 cycles. With CTRL_PERF_CNT_EN, instret_cnt=1 after the first retired instruction.
